// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// State encoding and timeout counter width used by the bridge and its counter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } e_apb_state;

  localparam int APB_TO_W = 8;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter: saturating, synchronous clear has priority over count.
// expired is a pure compare of the current count against limit (no added latency).
module apb_timeout_ctr
  import apb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [APB_TO_W-1:0] limit,
  output logic                expired,
  output logic [APB_TO_W-1:0] count
);

  logic [APB_TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {APB_TO_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == limit);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-command APB master: IDLE -> SETUP -> ACCESS (bounded wait on pready) -> RESP.
// Zero-wait response 3 cycles after accept; no buffering, cmd_ready only in IDLE; RESP holds until rsp_ready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [APB_TO_W-1:0] TO_LIMIT = APB_TO_W'(TIMEOUT_CYCLES - 1);

  e_apb_state            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic                  ctr_clr, ctr_en, ctr_expired;
  logic [APB_TO_W-1:0]   ctr_count;

  apb_timeout_ctr u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .limit   (TO_LIMIT),
    .expired (ctr_expired),
    .count   (ctr_count)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        ctr_clr   = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready wins over an expiry landing in the same cycle
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (ctr_expired) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          ctr_en = (ctr_count < TO_LIMIT);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, randomized transfers vs a transfer-level model,
// plus hand sequences for back-to-back throughput and reset during ACCESS.
module tb_apb_master_bridge;

  localparam int T = 16;

  logic       clk;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_addr;
  logic [8:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [8:0] rsp_rdata;
  logic       rsp_err, rsp_timeout;
  logic       psel, penable, pwrite;
  logic [1:0] paddr;
  logic [8:0] pwdata, prdata;
  logic       pready, pslverr;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(2), .DATA_WIDTH(9), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [8:0] wdata;
    int         waits;   // ACCESS cycles with pready low before it rises
    logic [8:0] prdata;
    logic       slverr;
    int         hold;    // cycles rsp_ready stays low once rsp_valid is seen
    logic [8:0] e_rdata;
    logic       e_err;
    logic       e_to;
    int         e_acc;   // expected ACCESS cycles
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h want %0h", tag, nm, act, exp);
    end
  endtask

  // Transfer-level reference: outcome depends only on wait count vs timeout budget.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.waits < T) begin
      r.e_acc   = v.waits + 1;
      r.e_rdata = v.wr ? 9'h000 : v.prdata;
      r.e_err   = v.slverr;
      r.e_to    = 1'b0;
    end else begin
      r.e_acc   = T;
      r.e_rdata = 9'h000;
      r.e_err   = 1'b1;
      r.e_to    = 1'b1;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int cyc, acc, psel_n, pen_n, rsp_cyc;
    logic stable;
    logic [8:0] h_rdata;
    logic h_err, h_to;
    @(negedge clk);
    chk(tag, "cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    rsp_ready = 1'b0;
    cyc = 0; acc = 0; psel_n = 0; pen_n = 0; rsp_cyc = -1; stable = 1'b1;
    while (rsp_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = 2'($urandom); cmd_wdata = 9'($urandom);
      if (psel) begin
        psel_n++;
        if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.wr) stable = 1'b0;
      end
      if (penable) pen_n++;
      if (rsp_valid) rsp_cyc = cyc;
      if (psel && penable) begin
        pready = (acc == v.waits); prdata = v.prdata; pslverr = v.slverr;
        acc++;
      end else begin
        pready = 1'($urandom); prdata = 9'($urandom); pslverr = 1'($urandom);
      end
    end
    chk(tag, "rsp_latency", 32'(rsp_cyc), 32'(2 + v.e_acc));
    chk(tag, "psel_cycles", 32'(psel_n), 32'(1 + v.e_acc));
    chk(tag, "penable_cycles", 32'(pen_n), 32'(v.e_acc));
    chk(tag, "bus_stable", 32'(stable), 32'd1);
    chk(tag, "rsp_rdata", 32'(rsp_rdata), 32'(v.e_rdata));
    chk(tag, "rsp_err", 32'(rsp_err), 32'(v.e_err));
    chk(tag, "rsp_timeout", 32'(rsp_timeout), 32'(v.e_to));
    h_rdata = v.e_rdata; h_err = v.e_err; h_to = v.e_to;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      pready = 1'($urandom); prdata = 9'($urandom); pslverr = 1'($urandom);
      chk(tag, "hold_valid", 32'(rsp_valid), 32'd1);
      chk(tag, "hold_rsp", {20'd0, rsp_rdata, rsp_err, rsp_timeout}, {20'd0, h_rdata, h_err, h_to});
      chk(tag, "hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk(tag, "hold_psel", 32'(psel), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk(tag, "post_valid", 32'(rsp_valid), 32'd0);
    chk(tag, "post_cmd_ready", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int acc_cyc[$];
    int rcount;
    vec_t rv;

    //             wr    addr  wdata   waits prdata  err  hold  e_rdata e_err e_to acc
    vecs[0] = '{1'b1, 2'd1, 9'h001,  0, 9'h1FF, 1'b0, 0, 9'h000, 1'b0, 1'b0,  1};
    vecs[1] = '{1'b0, 2'd2, 9'h03C,  3, 9'h0A5, 1'b0, 0, 9'h0A5, 1'b0, 1'b0,  4};
    vecs[2] = '{1'b0, 2'd3, 9'h000,  0, 9'h123, 1'b1, 1, 9'h123, 1'b1, 1'b0,  1};
    vecs[3] = '{1'b0, 2'd0, 9'h011, 16, 9'h055, 1'b0, 0, 9'h000, 1'b1, 1'b1, 16};
    vecs[4] = '{1'b0, 2'd1, 9'h022, 15, 9'h0AA, 1'b0, 0, 9'h0AA, 1'b0, 1'b0, 16};
    vecs[5] = '{1'b1, 2'd2, 9'h1FF,  2, 9'h155, 1'b1, 5, 9'h000, 1'b1, 1'b0,  3};
    vecs[6] = '{1'b1, 2'd3, 9'h0F0, 40, 9'h077, 1'b0, 2, 9'h000, 1'b1, 1'b1, 16};

    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", "bus", {28'd0, psel, penable, pwrite, rsp_valid}, 32'd0);
    chk("reset", "addr_data", {21'd0, paddr, pwdata}, 32'd0);
    chk("reset", "rsp", {21'd0, rsp_rdata, rsp_err, rsp_timeout}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset", "cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      rv.wr     = 1'($urandom);
      rv.addr   = 2'($urandom);
      rv.wdata  = 9'($urandom);
      rv.waits  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      rv.prdata = 9'($urandom);
      rv.slverr = 1'($urandom);
      rv.hold   = int'($urandom_range(0, 3));
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Back-to-back with rsp_ready and pready tied high: one accept every 4 cycles.
    @(negedge clk);
    rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 9'h0C3;
    rcount = 0;
    for (int c = 0; c < 20; c++) begin
      if (cmd_ready) acc_cyc.push_back(c);
      if (rsp_valid) rcount++;
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
    chk("b2b", "accepts", 32'(acc_cyc.size()), 32'd5);
    chk("b2b", "responses", 32'(rcount), 32'd5);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("b2b", $sformatf("interval%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd4);

    // Reset asserted during an ACCESS wait state.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3; pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid", "in_access", {30'd0, psel, penable}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("rstmid", "bus_drop", {29'd0, psel, penable, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pready = 1'b1; prdata = 9'h1AB;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstmid", $sformatf("quiet%0d", c), {29'd0, rsp_valid, psel, cmd_ready}, 32'd1);
    end
    pready = 1'b0;
    rv = '{1'b0, 2'd1, 9'h000, 1, 9'h0E1, 1'b0, 0, 9'h000, 1'b0, 1'b0, 0};
    rv = model(rv);
    run_txn(rv, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
